alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Iterative multiply/divide unit for the MIPS datapath; companion to the combinational ALU and owner of the architectural HI/LO registers. It accepts one MULT/MULTU/DIV/DIVU per start pulse and computes one bit per clock: shift-add for multiply, restoring division for divide. Results land in HI/LO after a fixed WIDTH+1 cycle latency. Parametrised in operand width; the pipeline stalls on `busy` for mflo/mfhi hazards.

## Interface
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be even and at least 4.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while `busy`=0.
- op_div  in  1  0 = multiply, 1 = divide.
- sign  in  1  1 = signed (MULT/DIV), 0 = unsigned; same meaning as ALU `Sign`.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM in three states:
  - IDLE: on `start`, latch |a|, |b| (magnitudes if `sign`, otherwise raw), the result signs, op, and a zero-divisor flag; counter := 0; go to CALC.
  - CALC: one iteration per cycle, WIDTH cycles; go to FIX when counter = WIDTH-1.
  - FIX: apply sign correction, write hi/lo, assert done; go to IDLE.
- Multiply: 2*WIDTH-bit accumulator. Signed result = two's complement of the magnitude product when a[W-1]^b[W-1].
- Divide, signed: quotient sign = a^b sign bits; remainder takes the sign of a. MIN/-1 gives lo=MIN, hi=0; no trap.
- Divide by zero (either signedness): lo = all ones, hi = a unmodified. Still takes the full latency.
- `start` while busy is ignored; the operand latches do not change.
- `done` cycle has busy=0, so `start` is accepted there (back-to-back).
- hi/lo hold their value between operations and during CALC; they change only in FIX (or via the HILO write port, see Configuration).

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0; state IDLE.
- Edge E0 samples start; busy=1 from E0 until E(WIDTH+1).
- At E(WIDTH+1): hi/lo updated, done=1 and busy=0 for one cycle.
- Latency: WIDTH+1 cycles from the accepting edge to result visibility (33 for WIDTH=32). Independent of operand values.
- reset_n low mid-operation aborts immediately: all outputs go to reset values and the partial result is discarded.
- No combinational path from inputs to outputs.

## Configuration
- `ALU_MULDIV_HILO_WRITE_EN` defined:
  - Adds ports hi_we (in, 1), lo_we (in, 1), wdata (in, WIDTH) for mthi/mtlo.
  - A write takes effect at the next edge, only when busy=0 and start=0; otherwise it is dropped.
  - hi_we and lo_we may be asserted together.
- Not defined: these ports are absent, and HI/LO are written only by FIX.

## Structure
- Package `alu_muldiv_pkg`:
  - state enum (IDLE, CALC, FIX);
  - op-select localparams (OP_MUL=0, OP_DIV=1);
  - helper function for two's-complement magnitude.
- Sub-module `alu_muldiv_step`: purely combinational, one iteration. Inputs: accumulator, operand, op_div. Output: the next accumulator, as either an add-shift or a trial-subtract-shift step. Instantiated once.

## Test plan
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start edge, busy high for 33 cycles.
- MULT -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100.
- start held high continuously with changing operands -> ops accepted only in IDLE and done cycles; each result matches the operands present at its accepting edge.
- reset_n pulsed low at cycle 10 of a DIVU -> hi=lo=0, busy=done=0 at once; a subsequent MULTU 6*7 gives lo=42, hi=0.
- With `ALU_MULDIV_HILO_WRITE_EN`: hi_we with wdata=0x1234 while idle -> hi=0x1234 at next edge; the same write while busy -> dropped, hi unchanged.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package alu_muldiv_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } state_e;

  // Encoding of the op_div input.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Widest value the helper below handles; must cover the 2*WIDTH product.
  localparam int unsigned MaxWidth = 128;

  // Returns -x when neg is set, x otherwise. Called with neg = sign bit it yields the
  // two's-complement magnitude; called with a result sign it re-applies that sign.
  // Callers zero-extend into MaxWidth and truncate back: the low bits of a negation
  // do not depend on the upper bits, so this is exact at any narrower width.
  function automatic logic [MaxWidth-1:0] twos_mag(input logic [MaxWidth-1:0] x,
                                                    input logic                neg);
    return neg ? (~x + MaxWidth'(1)) : x;
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Accumulator layout is {upper[WIDTH:0], lower[WIDTH-1:0]}:
//   multiply: upper = running partial product, lower = remaining multiplier bits;
//   divide:   upper = partial remainder,       lower = dividend bits / quotient bits.
module alu_muldiv_step
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             op_div_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Add-shift for multiply, trial-subtract-shift (restoring) for divide.
  always_comb begin
    sum  = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, operand_i} : '0);
    shl  = {acc_i[2*WIDTH-1:0], 1'b0};
    diff = shl[2*WIDTH:WIDTH] - {1'b0, operand_i};
    fits = (shl[2*WIDTH:WIDTH] >= {1'b0, operand_i});
    if (op_div_i == OP_MUL) begin
      // The sum never exceeds WIDTH+1 bits, so the top bit after the shift is zero.
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    end else if (fits) begin
      acc_o = {diff, shl[WIDTH-1:1], 1'b1};
    end else begin
      acc_o = shl;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers. One result bit per clock;
// results appear in HI/LO WIDTH+1 cycles after the accepting edge, with a one-cycle done.
// WIDTH must be even, at least 4, and at most MaxWidth/2.
// Optional build macro ALU_MULDIV_HILO_WRITE_EN adds the mthi/mtlo write port
// (hi_we, lo_we, wdata); writes land only while idle with no start request.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_MULDIV_HILO_WRITE_EN
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH + 1;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AccW-1:0]  acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             op_div_q, op_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  alu_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .operand_i(opnd_q),
    .op_div_i (op_div_q),
    .acc_o    (acc_step)
  );

  // Operand magnitudes at accept time and sign-corrected results at fix time.
  always_comb begin
    a_mag    = WIDTH'(twos_mag(MaxWidth'(a), sign & a[WIDTH-1]));
    b_mag    = WIDTH'(twos_mag(MaxWidth'(b), sign & b[WIDTH-1]));
    prod_fix = (2 * WIDTH)'(twos_mag(MaxWidth'(acc_q[2*WIDTH-1:0]), neg_res_q));
    quot_fix = WIDTH'(twos_mag(MaxWidth'(acc_q[WIDTH-1:0]), neg_res_q));
    rem_fix  = WIDTH'(twos_mag(MaxWidth'(acc_q[2*WIDTH-1:WIDTH]), neg_rem_q));
  end

  // Next-state logic for the controller, operand latches and HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    op_div_d   = op_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d      = {{(WIDTH + 1){1'b0}}, a_mag};
          opnd_d     = b_mag;
          a_raw_d    = a;
          op_div_d   = op_div;
          // Product and quotient share one sign rule; the remainder follows the dividend.
          neg_res_d  = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = sign & a[WIDTH-1];
          div_zero_d = (b == '0);
          cnt_d      = '0;
          state_d    = StCalc;
        end
`ifdef ALU_MULDIV_HILO_WRITE_EN
        else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
`endif
      end
      StCalc: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (op_div_q == OP_DIV) begin
          if (div_zero_q) begin
            // Divide by zero still runs the full latency, then reports a fixed pattern.
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      op_div_q   <= op_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed corner cases, random operations
// against an arithmetic reference model, back-to-back starts, and mid-operation reset.
module tb_alu_muldiv;

  localparam int W = 32;
  localparam int P = W + 2;  // edges between successive accepts when start is held high

  typedef struct {
    logic        od;
    logic        sg;
    logic [31:0] av;
    logic [31:0] bv;
  } op_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op_div;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef ALU_MULDIV_HILO_WRITE_EN
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
`endif

  int checks   = 0;
  int failures = 0;

  alu_muldiv #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op_div (op_div),
    .sign   (sign),
    .a      (a),
    .b      (b),
`ifdef ALU_MULDIV_HILO_WRITE_EN
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
`endif
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the MIPS HI/LO rules.
  function automatic void model(input logic od, input logic sg, input logic [31:0] av,
                                input logic [31:0] bv, output logic [31:0] eh,
                                output logic [31:0] el);
    logic [63:0] p;
    longint      q;
    longint      r;
    if (!od) begin
      if (sg) p = 64'(longint'($signed(av)) * longint'($signed(bv)));
      else    p = {32'd0, av} * {32'd0, bv};
      eh = p[63:32];
      el = p[31:0];
    end else if (bv == 32'd0) begin
      eh = av;
      el = 32'hFFFF_FFFF;
    end else if (sg) begin
      q  = longint'($signed(av)) / longint'($signed(bv));
      r  = longint'($signed(av)) % longint'($signed(bv));
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = av / bv;
      eh = av % bv;
    end
  endfunction

  // Issue one operation, then check latency, busy length, HI/LO hold and the result.
  task automatic run_op(input logic od, input logic sg, input logic [31:0] av,
                        input logic [31:0] bv, input string tag);
    logic [31:0] eh, el, ph, pl;
    int n, busy_cnt;
    model(od, sg, av, bv, eh, el);
    @(negedge clk);
    op_div = od; sign = sg; a = av; b = bv; start = 1'b1;
    ph = hi; pl = lo;
    @(posedge clk); #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    // Scramble inputs so a design that re-samples operands gets caught.
    a = $urandom; b = $urandom;
    op_div = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
    n = 0;
    while (n < W + 8) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (busy) busy_cnt++;
      if (n == 16) begin
        check({tag, " hold_hi"}, hi, ph);
        check({tag, " hold_lo"}, lo, pl);
      end
    end
    check({tag, " latency"}, 32'(n), 32'(W + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
  endtask

  initial begin
    op_t         pend[$];
    op_t         cur;
    logic [31:0] eh, el;

    clk = 1'b0; reset_n = 1'b0; start = 1'b0; op_div = 1'b0; sign = 1'b0;
    a = '0; b = '0;
`ifdef ALU_MULDIV_HILO_WRITE_EN
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed corner cases.
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max ref_hi", hi, 32'hFFFF_FFFE);
    check("multu_max ref_lo", lo, 32'h0000_0001);
    run_op(1'b0, 1'b1, -32'sd3, 32'sd5, "mult_neg");
    check("mult_neg ref_lo", lo, 32'hFFFF_FFF1);
    run_op(1'b1, 1'b1, -32'sd7, 32'sd2, "div_neg");
    check("div_neg ref_lo", lo, 32'hFFFF_FFFD);
    check("div_neg ref_hi", hi, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
    check("div_min ref_lo", lo, 32'h8000_0000);
    run_op(1'b1, 1'b1, -32'sd100, 32'd0, "div_zero_s");
    run_op(1'b1, 1'b0, 32'd100, 32'd0, "divu_zero");
    check("divu_zero ref_hi", hi, 32'd100);

    // Reset pulsed mid-DIVU, then a fresh MULTU.
    @(negedge clk);
    op_div = 1'b1; sign = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, 1'b0, 32'd6, 32'd7, "multu_6x7");
    check("multu_6x7 ref_lo", lo, 32'd42);

    // Random operations with a bias towards boundary operands.
    for (int i = 0; i < 24; i++) begin
      logic        od, sg;
      logic [31:0] av, bv;
      od = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       bv = 32'd0;
        1:       bv = 32'hFFFF_FFFF;
        2:       bv = $urandom_range(1, 9);
        default: bv = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) av = 32'h8000_0000;
      else                           av = $urandom;
      run_op(od, sg, av, bv, "rand");
    end

    // start held high with operands changing every cycle: accepts only at idle/done edges.
    for (int e = 0; e < 3 * P; e++) begin
      @(negedge clk);
      start  = 1'b1;
      op_div = 1'($urandom_range(0, 1));
      sign   = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (e % P == 0) pend.push_back(op_t'{op_div, sign, a, b});
      @(posedge clk); #1;
      check("b2b done", 32'(done), 32'(e % P == P - 1));
      check("b2b busy", 32'(busy), 32'(e % P != P - 1));
      if (done && pend.size() > 0) begin
        cur = pend.pop_front();
        model(cur.od, cur.sg, cur.av, cur.bv, eh, el);
        check("b2b hi", hi, eh);
        check("b2b lo", lo, el);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b all_retired", 32'(pend.size()), 32'd0);

`ifdef ALU_MULDIV_HILO_WRITE_EN
    // mthi/mtlo while idle, then a write attempted while busy.
    @(negedge clk);
    eh = hi; el = lo;
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    check("mthi hi", hi, 32'h0000_1234);
    check("mthi lo_kept", lo, el);
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5678;
    @(posedge clk); #1;
    check("mtlo lo", lo, 32'h0000_5678);
    check("mtlo hi_kept", hi, 32'h0000_1234);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_9ABC;
    @(posedge clk); #1;
    check("mthilo hi", hi, 32'h0000_9ABC);
    check("mthilo lo", lo, 32'h0000_9ABC);
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    op_div = 1'b0; sign = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_busy dropped", hi, 32'h0000_9ABC);
    begin
      int n;
      n = 0;
      while (!done && n < W + 8) begin
        @(posedge clk); #1;
        n++;
      end
      check("mthi_busy result_lo", lo, 32'd12);
      check("mthi_busy result_hi", hi, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
